muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide execution unit with architectural HI/LO registers, sitting beside the single-cycle ALU in the EX stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the decoder.
- Runs multiply/divide iteratively, one bit per cycle.
- Exposes busy so the pipeline stalls MFHI/MFLO and further mul/div issue until the result is committed.
- Supports a flush (cancel) for exceptions.

---
 rtl/muldiv_unit_pkg.sv | 40 ++++
 rtl/muldiv_unit_core.sv | 41 ++++
 rtl/muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_muldiv_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared opcodes, FSM state type and opcode-class helpers for the
// multiply/divide unit.
package muldiv_unit_pkg;

    localparam logic [2:0] MD_OP_NONE  = 3'd0;
    localparam logic [2:0] MD_OP_MULT  = 3'd1;
    localparam logic [2:0] MD_OP_MULTU = 3'd2;
    localparam logic [2:0] MD_OP_DIV   = 3'd3;
    localparam logic [2:0] MD_OP_DIVU  = 3'd4;
    localparam logic [2:0] MD_OP_MTHI  = 3'd5;
    localparam logic [2:0] MD_OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'd0,
        MD_CALC  = 2'd1,
        MD_FIXUP = 2'd2
    } md_state_t;

    function automatic logic is_muldiv(input logic [2:0] op);
        case (op)
            MD_OP_MULT, MD_OP_MULTU, MD_OP_DIV, MD_OP_DIVU: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        case (op)
            MD_OP_MULT, MD_OP_DIV: return 1'b1;
            default:               return 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        case (op)
            MD_OP_DIV, MD_OP_DIVU: return 1'b1;
            default:               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_unit_core.sv
// One iteration of the multiply (shift-add) or divide (restoring) datapath.
// acc holds {upper, lower}: product/multiplier for mul, remainder/quotient for div.
module muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     opd,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] diff_s;
    logic             ge_s;

    // Single step of either algorithm, selected by is_div.
    always_comb begin
        sum_s    = {1'b0, acc[2*WIDTH-1:WIDTH]};
        trial_s  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff_s   = trial_s[WIDTH-1:0] - opd;
        ge_s     = (trial_s >= {1'b0, opd});
        acc_next = acc;
        if (is_div) begin
            // The true difference is below the divisor, so the low WIDTH bits are exact.
            if (ge_s) begin
                acc_next = {diff_s, acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {trial_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (acc[0]) begin
                sum_s = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opd};
            end else begin
                sum_s = {1'b0, acc[2*WIDTH-1:WIDTH]};
            end
            acc_next = {sum_s, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers: FSM, iteration
// counter, operand sign handling and result commit.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    md_state_t          state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   opd_r;
    logic               is_div_r;
    logic               neg_res_r;
    logic               neg_rem_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;
    logic               div_zero_r;

    logic               a_neg_s;
    logic               b_neg_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [2*WIDTH-1:0] acc_next_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   fix_hi_s;
    logic [WIDTH-1:0]   fix_lo_s;

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .is_div   (is_div_r),
        .acc      (acc_r),
        .opd      (opd_r),
        .acc_next (acc_next_s)
    );

    // Operand magnitudes and signs for the request on the inputs.
    always_comb begin
        a_neg_s = is_signed_op(op) & a[WIDTH-1];
        b_neg_s = is_signed_op(op) & b[WIDTH-1];
        a_mag_s = a_neg_s ? ({WIDTH{1'b0}} - a) : a;
        b_mag_s = b_neg_s ? ({WIDTH{1'b0}} - b) : b;
    end

    // Sign fixup of the finished accumulator; divide by zero forces lo to all ones.
    always_comb begin
        prod_s = neg_res_r ? ({(2*WIDTH){1'b0}} - acc_r) : acc_r;
        if (is_div_r) begin
            fix_hi_s = neg_rem_r ? ({WIDTH{1'b0}} - acc_r[2*WIDTH-1:WIDTH])
                                 : acc_r[2*WIDTH-1:WIDTH];
            if (div_zero_r) begin
                fix_lo_s = {WIDTH{1'b1}};
            end else begin
                fix_lo_s = neg_res_r ? ({WIDTH{1'b0}} - acc_r[WIDTH-1:0])
                                     : acc_r[WIDTH-1:0];
            end
        end else begin
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Control FSM, iteration datapath registers and HI/LO commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= MD_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            acc_r      <= {(2*WIDTH){1'b0}};
            opd_r      <= {WIDTH{1'b0}};
            is_div_r   <= 1'b0;
            neg_res_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                MD_IDLE: begin
                    if (start && !cancel) begin
                        if (op == MD_OP_MTHI) begin
                            hi_r <= a;
                        end else if (op == MD_OP_MTLO) begin
                            lo_r <= a;
                        end else if (is_muldiv(op)) begin
                            state_r    <= MD_CALC;
                            busy_r     <= 1'b1;
                            cnt_r      <= {CNT_W{1'b0}};
                            is_div_r   <= is_div_op(op);
                            neg_res_r  <= a_neg_s ^ b_neg_s;
                            neg_rem_r  <= a_neg_s;
                            div_zero_r <= is_div_op(op) && (b == {WIDTH{1'b0}});
                            if (is_div_op(op)) begin
                                acc_r <= {{WIDTH{1'b0}}, a_mag_s};
                                opd_r <= b_mag_s;
                            end else begin
                                acc_r <= {{WIDTH{1'b0}}, b_mag_s};
                                opd_r <= a_mag_s;
                            end
                        end
                    end
                end
                MD_CALC: begin
                    if (cancel) begin
                        state_r <= MD_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        acc_r <= acc_next_s;
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (cnt_r == CNT_W'(WIDTH - 1)) begin
                            state_r <= MD_FIXUP;
                        end
                    end
                end
                MD_FIXUP: begin
                    state_r <= MD_IDLE;
                    busy_r  <= 1'b0;
                    if (!cancel) begin
                        hi_r   <= fix_hi_s;
                        lo_r   <= fix_lo_s;
                        done_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= MD_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign hi       = hi_r;
    assign lo       = lo_r;
    assign div_zero = div_zero_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a 32-bit and an 8-bit instance, expected
// results queued at issue and compared when done pulses.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, start, cancel;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    logic        rst8_n, start8, cancel8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, div_zero8;
    logic [7:0]  hi8, lo8;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .div_zero(div_zero)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst8_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .cancel(cancel8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8),
        .div_zero(div_zero8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one mul/div on the 32-bit unit; optionally push MTLO during the first busy cycles.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] ehi,
                          input logic [31:0] elo, input logic edz, input bit inject);
        int n;
        int busy_cnt;
        exp_t got;
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        sb.push_back('{ehi, elo, edz});
        @(posedge clk); #1;
        start = 1'b0; op = MD_OP_NONE;
        chk({tag, "_dz_at_accept"}, {31'd0, div_zero}, {31'd0, edz});
        n = 0; busy_cnt = 0;
        while (done !== 1'b1 && n < 200) begin
            if (busy === 1'b1) busy_cnt++;
            @(posedge clk); #1;
            n++;
            if (inject) begin
                if (n <= 3) begin
                    start = 1'b1; op = MD_OP_MTLO; a = 32'hDEADBEEF;
                end else begin
                    start = 1'b0; op = MD_OP_NONE;
                end
            end
        end
        // Accept edge counts as the first, so the commit is the 33rd edge after it.
        chk({tag, "_latency"}, n, 32'd33);
        chk({tag, "_busy_cycles"}, busy_cnt, 32'd33);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            chk({tag, "_hi"}, hi, got.hi);
            chk({tag, "_lo"}, lo, got.lo);
            chk({tag, "_dz"}, {31'd0, div_zero}, {31'd0, got.dz});
        end else begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end
    endtask

    initial begin
        int n8;
        logic [31:0] hold_hi, hold_lo;
        rst_n = 1'b0; start = 1'b0; cancel = 1'b0; op = MD_OP_NONE; a = 32'd0; b = 32'd0;
        rst8_n = 1'b0; start8 = 1'b0; cancel8 = 1'b0; op8 = MD_OP_NONE; a8 = 8'd0; b8 = 8'd0;
        start = 1'b1; op = MD_OP_MTHI; a = 32'h12345678;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_dz", {31'd0, div_zero}, 32'd0);
        start = 1'b0; op = MD_OP_NONE;
        @(negedge clk);
        rst_n = 1'b1; rst8_n = 1'b1;

        run_op("mult_neg", MD_OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0);
        run_op("multu_max", MD_OP_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_op("div_m7_2", MD_OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
        run_op("divu_zero", MD_OP_DIVU, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF, 1'b1, 1'b0);
        run_op("div_ovf", MD_OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
        run_op("div_neg_zero", MD_OP_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1'b0);

        // MTHI in idle lands on the next edge without busy or done.
        @(negedge clk);
        start = 1'b1; op = MD_OP_MTHI; a = 32'hCAFEF00D;
        @(posedge clk); #1;
        start = 1'b0; op = MD_OP_NONE;
        chk("mthi_hi", hi, 32'hCAFEF00D);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_done", {31'd0, done}, 32'd0);

        run_op("multu_inj", MD_OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b1);

        // Cancel-qualified MTHI in idle must be blocked.
        @(negedge clk);
        start = 1'b1; op = MD_OP_MTHI; a = 32'h55555555; cancel = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = MD_OP_NONE; cancel = 1'b0;
        chk("cancel_idle_hi", hi, 32'd0);

        // DIV aborted partway through CALC leaves HI/LO alone.
        hold_hi = 32'd0; hold_lo = 32'd12;
        @(negedge clk);
        start = 1'b1; op = MD_OP_DIV; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; op = MD_OP_NONE;
        repeat (10) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        chk("cancel_busy", {31'd0, busy}, 32'd0);
        chk("cancel_done", {31'd0, done}, 32'd0);
        n8 = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) n8++;
        end
        chk("cancel_no_done", n8, 32'd0);
        chk("cancel_hi", hi, hold_hi);
        chk("cancel_lo", lo, hold_lo);

        run_op("multu_after", MD_OP_MULTU, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 1'b0);

        // 8-bit instance: MULT 0x80 * 0x80, latency WIDTH+1 edges after accept.
        @(negedge clk);
        start8 = 1'b1; op8 = MD_OP_MULT; a8 = 8'h80; b8 = 8'h80;
        sb.push_back('{32'h40, 32'h00, 1'b0});
        @(posedge clk); #1;
        start8 = 1'b0; op8 = MD_OP_NONE;
        n8 = 0;
        while (done8 !== 1'b1 && n8 < 100) begin
            @(posedge clk); #1;
            n8++;
        end
        chk("w8_latency", n8, 32'd9);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("w8_hi", {24'd0, hi8}, e.hi);
            chk("w8_lo", {24'd0, lo8}, e.lo);
        end else begin
            chk("w8_sb_empty", 32'd0, 32'd1);
        end

        // Reset mid-CALC discards the operation and clears everything.
        @(negedge clk);
        start8 = 1'b1; op8 = MD_OP_DIVU; a8 = 8'h05; b8 = 8'h00;
        @(posedge clk); #1;
        start8 = 1'b0; op8 = MD_OP_NONE;
        chk("w8_dz_set", {31'd0, div_zero8}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        rst8_n = 1'b0;
        @(posedge clk); #1;
        chk("w8_rst_busy", {31'd0, busy8}, 32'd0);
        chk("w8_rst_done", {31'd0, done8}, 32'd0);
        chk("w8_rst_hi", {24'd0, hi8}, 32'd0);
        chk("w8_rst_lo", {24'd0, lo8}, 32'd0);
        chk("w8_rst_dz", {31'd0, div_zero8}, 32'd0);
        rst8_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("w8_rst_stays_idle", {31'd0, busy8 | done8}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
